rx_flit_classifier: RTL and testbench
=====================================

# rx_flit_classifier

Receive-side flit classification stage directly upstream of the implicit Rx flit sequence number tracker. Takes one decoded flit per cycle from the CRC/FEC check stage and turns it into registered, one-cycle event pulses plus the context levels that the sequence tracker consumes. Context levels: prior-flit-was-payload, sticky explicit-sequence-seen, and the NAK-withdrawal window. All context is presented as it stood *before* the current flit, aligned with that flit's pulses.

## Interface
Parameters:
- NAK_WITHDRAW_FLITS, 4: number of received flits after a NAK during which NAK withdrawal is allowed (1..255).
- SEQ_W, 8: flit sequence number width.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- link_up  in  1  link active; 0 synchronously clears sticky context
- flit_valid  in  1  one flit presented this cycle
- flit_crc_ok  in  1  CRC/FEC passed for presented flit
- flit_type  in  2  0 IDLE, 1 NOP, 2 PAYLOAD, 3 reserved
- flit_explicit_seq  in  1  header carries explicit sequence number
- flit_hdr_seq  in  SEQ_W  header sequence number field
- nak_sent  in  1  pulse: Tx side scheduled a NAK
- idleFlitReceived, validNopFlitReceived, validPayloadFlitReceived  out  1 each  pulses
- explicitSeqNumFlitReceived, validNonIdleExplicitSeqNumFlitReceived, nonExplicitSeqNumFlitReceived, invalidFlitReceived, flitseqnum0  out  1 each  pulses
- flitSeqNum  out  SEQ_W  sequence number of current explicit flit, else 0
- priorFlitWasPayload, nonIdleExplicitSeqNumFlitRcvd, nakWithdrawalAllowed  out  1 each  context levels

## Operation
- good = flit_valid & flit_crc_ok & (flit_type != 3).
- invalidFlitReceived = flit_valid & !good. A reserved type counts as invalid.
- idle/NOP/payload pulses: good & matching type.
- explicitSeqNumFlitReceived = good & flit_explicit_seq.
- validNonIdleExplicitSeqNumFlitReceived = that & type != IDLE.
- nonExplicitSeqNumFlitReceived = good & !flit_explicit_seq & type != IDLE.
- flitseqnum0 = explicitSeqNumFlitReceived & flit_hdr_seq == 0.
- flitSeqNum = flit_hdr_seq when explicitSeqNumFlitReceived, else 0.
- Internal prior_payload: on every flit_valid, loads good & type == PAYLOAD. An invalid flit clears it.
- Internal seen_explicit: sticky. Set by a valid non-idle explicit flit with seq != 0. Cleared by reset or link_up=0.
- NAK window counter, width $clog2(NAK_WITHDRAW_FLITS+1):
  - nak_sent loads NAK_WITHDRAW_FLITS, reloading if already running.
  - Otherwise each flit_valid decrements it, saturating at 0.
  - Window = counter != 0.
- Context outputs sample the internal state before that cycle's update.
- Simultaneous flit_valid and nak_sent: the flit sees the old window; the load wins over the decrement.
- link_up=0 with flit_valid: the flit is still classified. It sees the pre-clear context, then all context clears.

## Timing
- Latency 1: inputs at edge T produce all outputs valid for cycle T+1.
- Pulses are high for exactly one cycle; back-to-back flits are accepted every cycle with no bubbles.
- No flit_valid: all pulses 0 and flitSeqNum 0; context outputs hold their last value.
- Reset: all outputs 0, counter 0, internal state 0. Asserting reset mid-stream discards any in-flight flit.

## Configuration
- RX_FLIT_STATS_EN defined: adds ports invalid_flit_cnt and payload_flit_cnt (out, 16 bits each).
  - Saturating counters, incremented on invalidFlitReceived and validPayloadFlitReceived respectively.
  - Same latency as the pulses; cleared only by reset.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package flit_rx_pkg holds the flit_type_e enum (IDLE, NOP, PAYLOAD, RSVD) and the FLIT_SEQ_W constant.
- Sub-module nak_withdraw_window contains the load/decrement counter and the window flag. Parameterised by NAK_WITHDRAW_FLITS.

## Test plan
- Reset, then good PAYLOAD explicit seq 5 at T → T+1: validPayloadFlitReceived, explicitSeqNumFlitReceived and validNonIdleExplicit all 1; flitSeqNum=5; nonIdleExplicitSeqNumFlitRcvd=0. The next flit sees nonIdleExplicitSeqNumFlitRcvd=1 and priorFlitWasPayload=1.
- Good flit with flit_crc_ok=0, then a NOP → invalidFlitReceived pulses; the NOP's cycle shows priorFlitWasPayload=0.
- Explicit flit with seq 0 → flitseqnum0=1; the sticky flag stays 0.
- nak_sent, then 5 back-to-back flits (NAK_WITHDRAW_FLITS=4) → nakWithdrawalAllowed=1 for flits 1–4 and 0 for flit 5. nak_sent coincident with flit 1 → flit 1 sees 0.
- IDLE flits, reserved type, link_up drop after explicit flit → correct idle/invalid pulses; sticky flag cleared on the following flit.
- With RX_FLIT_STATS_EN: 70000 invalid flits → invalid_flit_cnt saturates at 65535.

Source files
------------

// File: rtl/flit_rx_pkg.sv
// Shared types and constants for the receive-side flit classification path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package flit_rx_pkg;

    localparam int FLIT_SEQ_W = 8;

    // Two-bit flit type carried in the decoded header; RSVD is never legal on the wire.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NOP     = 2'd1,
        PAYLOAD = 2'd2,
        RSVD    = 2'd3
    } flit_type_e;

endpackage

// File: rtl/nak_withdraw_window.sv
// Counts received flits after a NAK; window is open while the count is non-zero.
// Latency: window reflects the count after the previous edge (no combinational path from inputs).
// Backpressure: none; load, step and clear are accepted every cycle, clear > load > step.
module nak_withdraw_window #(
    parameter int NAK_WITHDRAW_FLITS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic load,
    input  logic step,
    output logic window
);

    localparam int CNT_W = $clog2(NAK_WITHDRAW_FLITS + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(NAK_WITHDRAW_FLITS);

    logic [CNT_W-1:0] cnt;

    // Reload on NAK (restarting a running window), otherwise count flits down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (step && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign window = (cnt != '0);

endmodule

// File: rtl/rx_flit_classifier.sv
// Classifies each decoded Rx flit into registered event pulses plus pre-flit context levels.
// Latency: 1 cycle from flit inputs to all outputs; RX_FLIT_STATS_EN adds 16-bit saturating counters.
// Backpressure: none; one flit accepted every cycle, back-to-back without bubbles.
module rx_flit_classifier
    import flit_rx_pkg::*;
#(
    parameter int NAK_WITHDRAW_FLITS = 4,
    parameter int SEQ_W              = FLIT_SEQ_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             link_up,
    input  logic             flit_valid,
    input  logic             flit_crc_ok,
    input  logic [1:0]       flit_type,
    input  logic             flit_explicit_seq,
    input  logic [SEQ_W-1:0] flit_hdr_seq,
    input  logic             nak_sent,
    output logic             idleFlitReceived,
    output logic             validNopFlitReceived,
    output logic             validPayloadFlitReceived,
    output logic             explicitSeqNumFlitReceived,
    output logic             validNonIdleExplicitSeqNumFlitReceived,
    output logic             nonExplicitSeqNumFlitReceived,
    output logic             invalidFlitReceived,
    output logic             flitseqnum0,
    output logic [SEQ_W-1:0] flitSeqNum,
    output logic             priorFlitWasPayload,
    output logic             nonIdleExplicitSeqNumFlitRcvd,
    output logic             nakWithdrawalAllowed
`ifdef RX_FLIT_STATS_EN
    ,
    output logic [15:0]      invalid_flit_cnt,
    output logic [15:0]      payload_flit_cnt
`endif
);

    flit_type_e ftype;
    logic       good;
    logic       nonidle;
    logic       explicit_ok;
    logic       explicit_nonidle;
    logic       payload_ok;
    logic       invalid;
    logic       prior_payload;
    logic       seen_explicit;
    logic       window;

    assign ftype            = flit_type_e'(flit_type);
    assign good             = flit_valid & flit_crc_ok & (ftype != RSVD);
    assign nonidle          = (ftype != IDLE);
    assign explicit_ok      = good & flit_explicit_seq;
    assign explicit_nonidle = explicit_ok & nonidle;
    assign payload_ok       = good & (ftype == PAYLOAD);
    assign invalid          = flit_valid & ~good;

    // Event pulses: recomputed every cycle, so they are naturally zero when no flit is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idleFlitReceived                       <= 1'b0;
            validNopFlitReceived                   <= 1'b0;
            validPayloadFlitReceived               <= 1'b0;
            explicitSeqNumFlitReceived             <= 1'b0;
            validNonIdleExplicitSeqNumFlitReceived <= 1'b0;
            nonExplicitSeqNumFlitReceived          <= 1'b0;
            invalidFlitReceived                    <= 1'b0;
            flitseqnum0                            <= 1'b0;
            flitSeqNum                             <= '0;
        end else begin
            idleFlitReceived                       <= good & (ftype == IDLE);
            validNopFlitReceived                   <= good & (ftype == NOP);
            validPayloadFlitReceived               <= payload_ok;
            explicitSeqNumFlitReceived             <= explicit_ok;
            validNonIdleExplicitSeqNumFlitReceived <= explicit_nonidle;
            nonExplicitSeqNumFlitReceived          <= good & ~flit_explicit_seq & nonidle;
            invalidFlitReceived                    <= invalid;
            flitseqnum0                            <= explicit_ok & (flit_hdr_seq == '0);
            flitSeqNum                             <= explicit_ok ? flit_hdr_seq : '0;
        end
    end

    // Context levels capture internal state as it stood before the presented flit; held between flits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            priorFlitWasPayload           <= 1'b0;
            nonIdleExplicitSeqNumFlitRcvd <= 1'b0;
            nakWithdrawalAllowed          <= 1'b0;
        end else if (flit_valid) begin
            priorFlitWasPayload           <= prior_payload;
            nonIdleExplicitSeqNumFlitRcvd <= seen_explicit;
            nakWithdrawalAllowed          <= window;
        end
    end

    // Internal context: prior-payload follows each flit, explicit-seen is sticky; link down clears both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prior_payload <= 1'b0;
            seen_explicit <= 1'b0;
        end else if (!link_up) begin
            prior_payload <= 1'b0;
            seen_explicit <= 1'b0;
        end else begin
            if (flit_valid) begin
                prior_payload <= payload_ok;
            end
            if (explicit_nonidle && (flit_hdr_seq != '0)) begin
                seen_explicit <= 1'b1;
            end
        end
    end

    nak_withdraw_window #(
        .NAK_WITHDRAW_FLITS (NAK_WITHDRAW_FLITS)
    ) u_nak_window (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~link_up),
        .load    (nak_sent),
        .step    (flit_valid),
        .window  (window)
    );

`ifdef RX_FLIT_STATS_EN
    // Saturating statistics, updated on the same edge as the matching pulse; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            invalid_flit_cnt <= '0;
            payload_flit_cnt <= '0;
        end else begin
            if (invalid && (invalid_flit_cnt != 16'hFFFF)) begin
                invalid_flit_cnt <= invalid_flit_cnt + 16'd1;
            end
            if (payload_ok && (payload_flit_cnt != 16'hFFFF)) begin
                payload_flit_cnt <= payload_flit_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_flit_classifier.sv
// Directed bench for rx_flit_classifier with hand-computed expectations.
// Latency: checks sample 1 time unit after the edge that registers each flit.
// Backpressure: n/a; flits are driven back to back or with explicit idle cycles.
module tb_rx_flit_classifier;
    import flit_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       link_up = 1'b0;
    logic       flit_valid = 1'b0;
    logic       flit_crc_ok = 1'b0;
    logic [1:0] flit_type = 2'd0;
    logic       flit_explicit_seq = 1'b0;
    logic [7:0] flit_hdr_seq = 8'd0;
    logic       nak_sent = 1'b0;

    logic       idle_p, nop_p, pay_p, expl_p, nie_p, nonexpl_p, inv_p, seq0_p;
    logic [7:0] seq_num;
    logic       prior_pay, sticky, nak_win;
`ifdef RX_FLIT_STATS_EN
    logic [15:0] inv_cnt, pay_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rx_flit_classifier #(.NAK_WITHDRAW_FLITS(4), .SEQ_W(8)) dut (
        .clk                                    (clk),
        .reset_n                                (reset_n),
        .link_up                                (link_up),
        .flit_valid                             (flit_valid),
        .flit_crc_ok                            (flit_crc_ok),
        .flit_type                              (flit_type),
        .flit_explicit_seq                      (flit_explicit_seq),
        .flit_hdr_seq                           (flit_hdr_seq),
        .nak_sent                               (nak_sent),
        .idleFlitReceived                       (idle_p),
        .validNopFlitReceived                   (nop_p),
        .validPayloadFlitReceived               (pay_p),
        .explicitSeqNumFlitReceived             (expl_p),
        .validNonIdleExplicitSeqNumFlitReceived (nie_p),
        .nonExplicitSeqNumFlitReceived          (nonexpl_p),
        .invalidFlitReceived                    (inv_p),
        .flitseqnum0                            (seq0_p),
        .flitSeqNum                             (seq_num),
        .priorFlitWasPayload                    (prior_pay),
        .nonIdleExplicitSeqNumFlitRcvd          (sticky),
        .nakWithdrawalAllowed                   (nak_win)
`ifdef RX_FLIT_STATS_EN
        ,
        .invalid_flit_cnt                       (inv_cnt),
        .payload_flit_cnt                       (pay_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Present one cycle of inputs, then move to just after the registering edge.
    task automatic drive(input logic v, input logic crc, input logic [1:0] t,
                         input logic ex, input logic [7:0] seq, input logic nak);
        flit_valid = v; flit_crc_ok = crc; flit_type = t;
        flit_explicit_seq = ex; flit_hdr_seq = seq; nak_sent = nak;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_reset();
        logic [19:0] all_out;
        reset_n = 1'b0; link_up = 1'b0;
        repeat (2) idle_cycle();
        all_out = {idle_p, nop_p, pay_p, expl_p, nie_p, nonexpl_p, inv_p, seq0_p, seq_num, prior_pay, sticky, nak_win, 1'b0};
        checks++; if (all_out !== 20'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_out); end
        reset_n = 1'b1; link_up = 1'b1;
        idle_cycle();
    endtask

    task automatic test_payload_explicit();
        drive(1'b1, 1'b1, PAYLOAD, 1'b1, 8'd5, 1'b0);
        checks++; if ({pay_p, expl_p, nie_p} !== 3'b111) begin errors++; $display("FAIL pay5_pulses got %b exp 111", {pay_p, expl_p, nie_p}); end
        checks++; if ({idle_p, nop_p, nonexpl_p, inv_p, seq0_p} !== 5'b0) begin errors++; $display("FAIL pay5_other got %b exp 00000", {idle_p, nop_p, nonexpl_p, inv_p, seq0_p}); end
        checks++; if (seq_num !== 8'd5) begin errors++; $display("FAIL pay5_seq got %0d exp 5", seq_num); end
        checks++; if ({sticky, prior_pay} !== 2'b00) begin errors++; $display("FAIL pay5_ctx got %b exp 00", {sticky, prior_pay}); end
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd9, 1'b0);
        checks++; if ({nop_p, nonexpl_p, expl_p} !== 3'b110) begin errors++; $display("FAIL nop_pulses got %b exp 110", {nop_p, nonexpl_p, expl_p}); end
        checks++; if (seq_num !== 8'd0) begin errors++; $display("FAIL nop_seq got %0d exp 0", seq_num); end
        checks++; if ({sticky, prior_pay} !== 2'b11) begin errors++; $display("FAIL nop_ctx got %b exp 11", {sticky, prior_pay}); end
    endtask

    task automatic test_no_flit_hold();
        drive(1'b1, 1'b1, PAYLOAD, 1'b0, 8'd0, 1'b0);
        idle_cycle();
        checks++; if ({idle_p, nop_p, pay_p, expl_p, nie_p, nonexpl_p, inv_p, seq0_p} !== 8'd0 || seq_num !== 8'd0) begin
            errors++; $display("FAIL idle_pulses got %b seq %0d exp 0", {idle_p, nop_p, pay_p, expl_p, nie_p, nonexpl_p, inv_p, seq0_p}, seq_num); end
        checks++; if ({prior_pay, sticky} !== 2'b01) begin errors++; $display("FAIL idle_hold got %b exp 01", {prior_pay, sticky}); end
    endtask

    task automatic test_invalid();
        drive(1'b1, 1'b1, PAYLOAD, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, PAYLOAD, 1'b1, 8'd3, 1'b0);
        checks++; if ({inv_p, pay_p, expl_p} !== 3'b100) begin errors++; $display("FAIL crcbad_pulses got %b exp 100", {inv_p, pay_p, expl_p}); end
        checks++; if (prior_pay !== 1'b1) begin errors++; $display("FAIL crcbad_prior got %b exp 1", prior_pay); end
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if ({nop_p, inv_p, prior_pay} !== 3'b100) begin errors++; $display("FAIL after_inv got %b exp 100", {nop_p, inv_p, prior_pay}); end
    endtask

    task automatic test_seq0();
        link_up = 1'b0; idle_cycle(); link_up = 1'b1;
        drive(1'b1, 1'b1, PAYLOAD, 1'b1, 8'd0, 1'b0);
        checks++; if ({seq0_p, expl_p, nie_p} !== 3'b111) begin errors++; $display("FAIL seq0_pulses got %b exp 111", {seq0_p, expl_p, nie_p}); end
        checks++; if (seq_num !== 8'd0) begin errors++; $display("FAIL seq0_num got %0d exp 0", seq_num); end
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if (sticky !== 1'b0 || seq0_p !== 1'b0) begin errors++; $display("FAIL seq0_sticky got %b%b exp 00", sticky, seq0_p); end
    endtask

    task automatic test_nak_window();
        logic [4:0] exp_win;
        logic [4:0] got_win;
        exp_win = 5'b01111;
        got_win = '0;
        drive(1'b0, 1'b0, IDLE, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
            got_win[i] = nak_win;
        end
        checks++; if (got_win !== exp_win) begin errors++; $display("FAIL nak_window got %b exp %b", got_win, exp_win); end
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b1);
        checks++; if (nak_win !== 1'b0) begin errors++; $display("FAIL nak_coincident got %b exp 0", nak_win); end
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if (nak_win !== 1'b1) begin errors++; $display("FAIL nak_after_load got %b exp 1", nak_win); end
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b1);
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if (nak_win !== 1'b1) begin errors++; $display("FAIL nak_reload got %b exp 1", nak_win); end
    endtask

    task automatic test_idle_rsvd_link();
        drive(1'b1, 1'b1, IDLE, 1'b1, 8'd3, 1'b0);
        checks++; if ({idle_p, expl_p, nie_p, nonexpl_p} !== 4'b1100 || seq_num !== 8'd3) begin
            errors++; $display("FAIL idle_expl got %b seq %0d exp 1100 seq 3", {idle_p, expl_p, nie_p, nonexpl_p}, seq_num); end
        drive(1'b1, 1'b1, IDLE, 1'b0, 8'd0, 1'b0);
        checks++; if ({idle_p, expl_p, nonexpl_p, inv_p} !== 4'b1000) begin errors++; $display("FAIL idle_plain got %b exp 1000", {idle_p, expl_p, nonexpl_p, inv_p}); end
        drive(1'b1, 1'b1, RSVD, 1'b1, 8'd4, 1'b0);
        checks++; if ({inv_p, idle_p, nop_p, pay_p, expl_p, nonexpl_p} !== 6'b100000 || seq_num !== 8'd0) begin
            errors++; $display("FAIL rsvd got %b seq %0d exp 100000 seq 0", {inv_p, idle_p, nop_p, pay_p, expl_p, nonexpl_p}, seq_num); end
        drive(1'b1, 1'b1, NOP, 1'b1, 8'd7, 1'b0);
        link_up = 1'b0;
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if ({nop_p, sticky} !== 2'b11) begin errors++; $display("FAIL linkdown_flit got %b exp 11", {nop_p, sticky}); end
        link_up = 1'b1;
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if ({sticky, nak_win} !== 2'b00) begin errors++; $display("FAIL linkdown_clear got %b exp 00", {sticky, nak_win}); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b1, PAYLOAD, 1'b1, 8'd9, 1'b0);
        flit_valid = 1'b1; flit_crc_ok = 1'b1; flit_type = NOP; flit_explicit_seq = 1'b1; flit_hdr_seq = 8'd6;
        #3 reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({nop_p, pay_p, expl_p, seq_num, prior_pay, sticky} !== 13'd0) begin
            errors++; $display("FAIL midreset got %b exp 0", {nop_p, pay_p, expl_p, seq_num, prior_pay, sticky}); end
        reset_n = 1'b1;
        drive(1'b1, 1'b1, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if ({prior_pay, sticky} !== 2'b00) begin errors++; $display("FAIL midreset_ctx got %b exp 00", {prior_pay, sticky}); end
    endtask

`ifdef RX_FLIT_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0; idle_cycle(); reset_n = 1'b1;
        repeat (3) drive(1'b1, 1'b1, PAYLOAD, 1'b0, 8'd0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, NOP, 1'b0, 8'd0, 1'b0);
        checks++; if (pay_cnt !== 16'd3 || inv_cnt !== 16'd2) begin errors++; $display("FAIL stats_small got %0d/%0d exp 3/2", pay_cnt, inv_cnt); end
        repeat (70000) drive(1'b1, 1'b1, RSVD, 1'b0, 8'd0, 1'b0);
        checks++; if (inv_cnt !== 16'hFFFF || pay_cnt !== 16'd3) begin errors++; $display("FAIL stats_sat got %0d/%0d exp 65535/3", inv_cnt, pay_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_payload_explicit();
        test_no_flit_hold();
        test_invalid();
        test_seq0();
        test_nak_window();
        test_idle_rsvd_link();
        test_reset_midstream();
`ifdef RX_FLIT_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
